inst_encoder: RTL and testbench

- Sequential RISC-V RV32I instruction encoder and loader; it performs the inverse of the ID-stage decoder.
- Accepts field-level instruction commands over a valid/ready stream and packs them into 32-bit instruction words.
- Writes the words to consecutive instruction-memory addresses through a BRAM-style write port.
- Used by the debug/bootstrap path to build test programs in instruction memory without an external toolchain.

---
 rtl/inst_encoder_if.sv | 37 +++
 rtl/inst_encoder.sv | 220 ++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_encoder_if.sv
// Command stream and instruction-memory write port of the RV32I encoder.
// master = command source / memory sink, slave = the encoder itself.
// No logic; pure signal bundle.
interface inst_encoder_if #(
  parameter int ADDR_W = 12
);
  // command stream (valid/ready)
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_fmt;
  logic [6:0]        cmd_opcode;
  logic [2:0]        cmd_fn3;
  logic [6:0]        cmd_fn7;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [31:0]       cmd_imm;
  logic              cmd_last;
  // instruction-memory write port (never stalls)
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output cmd_valid, cmd_fmt, cmd_opcode, cmd_fn3, cmd_fn7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    input  cmd_ready,
    input  imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  cmd_valid, cmd_fmt, cmd_opcode, cmd_fn3, cmd_fn7,
           cmd_rd, cmd_rs1, cmd_rs2, cmd_imm, cmd_last,
    output cmd_ready,
    output imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs field-level RV32I commands into instruction words and writes them to consecutive imem addresses.
// Latency: a command accepted in cycle N is written (imem_we) in cycle N+2; one word per cycle.
// Backpressure: cmd_ready low outside LOAD, after the last/overflowing command, or when DEPTH words were taken.
module inst_encoder #(
  parameter int          ADDR_W   = 12,
  parameter int          DEPTH    = 4096,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  inst_encoder_if.slave     bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  output logic [7:0]        err_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE, ST_OVF} state_t;

  // fields captured by stage 1
  typedef struct packed {
    logic [2:0]        fmt;
    logic [6:0]        op;
    logic [2:0]        fn3;
    logic [6:0]        fn7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              legal;
    logic              last;
    logic              ovf;
    logic [ADDR_W-1:0] addr;
  } s1_t;

  state_t            state_q;
  logic              busy_q, done_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              closed_q;   // last (or the overflowing command) already taken
  logic [7:0]        err_q;

  logic              s1_vld_q;
  s1_t               s1_q, s1_d;

  logic              s2_vld_q;
  logic [ADDR_W-1:0] s2_addr_q;
  logic [31:0]       s2_wdata_q;
  logic              s2_last_q, s2_ovf_q, s2_ill_q;

  logic              cmd_ready;
  logic              accept;
  logic              legal_d;
  logic              ovf_tag;
  logic signed [31:0] imm_s;
  logic              in_shift;
  logic              s1_shift;
  logic [31:0]       word_d;

  // ready depends on registered state only, never on cmd_valid
  assign cmd_ready = (state_q == ST_LOAD) && !closed_q && (cnt_q < DEPTH_C);
  assign accept    = bus.cmd_valid && cmd_ready;

  // this command is the final word that fits, either by count or by address wrap
  assign ovf_tag   = !bus.cmd_last && ((cnt_q == LAST_IDX) || (addr_q == '1));

  assign imm_s     = $signed(bus.cmd_imm);
  assign in_shift  = (bus.cmd_fn3 == 3'b001) || (bus.cmd_fn3 == 3'b101);
  assign s1_shift  = (s1_q.fn3 == 3'b001) || (s1_q.fn3 == 3'b101);

  // immediate range/alignment check on the incoming command
  always_comb begin
    legal_d = 1'b0;
    case (bus.cmd_fmt)
      FMT_R: legal_d = 1'b1;
      FMT_I: begin
        if (in_shift) legal_d = (imm_s >= 32'sd0) && (imm_s <= 32'sd31);
        else          legal_d = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      end
      FMT_S: legal_d = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      FMT_B: legal_d = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.cmd_imm[0];
      FMT_U: legal_d = (bus.cmd_imm[11:0] == 12'h000);
      FMT_J: legal_d = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !bus.cmd_imm[0];
      default: legal_d = 1'b0;
    endcase
  end

  // stage-1 next value: raw fields plus legality and the target address
  always_comb begin
    s1_d       = s1_q;
    s1_d.fmt   = bus.cmd_fmt;
    s1_d.op    = bus.cmd_opcode;
    s1_d.fn3   = bus.cmd_fn3;
    s1_d.fn7   = bus.cmd_fn7;
    s1_d.rd    = bus.cmd_rd;
    s1_d.rs1   = bus.cmd_rs1;
    s1_d.rs2   = bus.cmd_rs2;
    s1_d.imm   = bus.cmd_imm;
    s1_d.legal = legal_d;
    s1_d.last  = bus.cmd_last;
    s1_d.ovf   = ovf_tag;
    s1_d.addr  = addr_q;
  end

  // RV32I bit placement; illegal commands collapse to the NOP word
  always_comb begin
    word_d = NOP_WORD;
    case (s1_q.fmt)
      FMT_R: word_d = {s1_q.fn7, s1_q.rs2, s1_q.rs1, s1_q.fn3, s1_q.rd, s1_q.op};
      FMT_I: begin
        if (s1_shift) word_d = {s1_q.fn7, s1_q.imm[4:0], s1_q.rs1, s1_q.fn3, s1_q.rd, s1_q.op};
        else          word_d = {s1_q.imm[11:0], s1_q.rs1, s1_q.fn3, s1_q.rd, s1_q.op};
      end
      FMT_S: word_d = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.fn3, s1_q.imm[4:0], s1_q.op};
      FMT_B: word_d = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.fn3,
                       s1_q.imm[4:1], s1_q.imm[11], s1_q.op};
      FMT_U: word_d = {s1_q.imm[31:12], s1_q.rd, s1_q.op};
      FMT_J: word_d = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                       s1_q.rd, s1_q.op};
      default: word_d = NOP_WORD;
    endcase
    if (!s1_q.legal) word_d = NOP_WORD;
  end

  // two-stage pipeline, never stalls; reset drops anything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s1_q       <= '0;
      s2_vld_q   <= 1'b0;
      s2_addr_q  <= '0;
      s2_wdata_q <= '0;
      s2_last_q  <= 1'b0;
      s2_ovf_q   <= 1'b0;
      s2_ill_q   <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) s1_q <= s1_d;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_addr_q  <= s1_q.addr;
        s2_wdata_q <= word_d;
        s2_last_q  <= s1_q.last;
        s2_ovf_q   <= s1_q.ovf;
        s2_ill_q   <= !s1_q.legal;
      end
    end
  end

  // load sequencer: address/count bookkeeping, error count and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      closed_q <= 1'b0;
      err_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_OVF: begin
          if (start_i) begin
            state_q  <= ST_LOAD;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            addr_q   <= base_addr_i;
            cnt_q    <= '0;
            closed_q <= 1'b0;
            err_q    <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            addr_q <= addr_q + 1'b1;
            cnt_q  <= cnt_q + 1'b1;
            if (bus.cmd_last || ovf_tag) closed_q <= 1'b1;
          end
          if (s2_vld_q && s2_ill_q && (err_q != 8'hFF)) err_q <= err_q + 1'b1;
          // finish once the closing word has actually been written
          if (s2_vld_q && s2_last_q) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (s2_vld_q && s2_ovf_q) begin
            state_q <= ST_OVF;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.imem_we    = s2_vld_q;
  assign bus.imem_addr  = s2_addr_q;
  assign bus.imem_wdata = s2_wdata_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign ovf_o          = ovf_q;
  assign err_cnt_o      = err_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: one default instance and one with DEPTH=4.
// Table of encode vectors streamed as one load, plus directed sequences
// for reset, idle/after-last holdoff, overflow, wrap and start-during-write.
module tb_inst_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // shared command fields, separate valid/start per instance
  logic [2:0]  c_fmt = '0;
  logic [6:0]  c_op = '0;
  logic [2:0]  c_fn3 = '0;
  logic [6:0]  c_fn7 = '0;
  logic [4:0]  c_rd = '0, c_rs1 = '0, c_rs2 = '0;
  logic [31:0] c_imm = '0;
  logic        c_last = 1'b0;
  logic        c_v0 = 1'b0, c_v4 = 1'b0;
  logic        st0 = 1'b0, st4 = 1'b0;
  logic [11:0] ba0 = '0, ba4 = '0;

  logic busy0, done0, ovf0, busy4, done4, ovf4;
  logic [7:0] err0, err4;

  inst_encoder_if #(.ADDR_W(12)) if0 ();
  inst_encoder_if #(.ADDR_W(12)) if4 ();

  assign if0.cmd_valid = c_v0;   assign if4.cmd_valid = c_v4;
  assign if0.cmd_fmt = c_fmt;    assign if4.cmd_fmt = c_fmt;
  assign if0.cmd_opcode = c_op;  assign if4.cmd_opcode = c_op;
  assign if0.cmd_fn3 = c_fn3;    assign if4.cmd_fn3 = c_fn3;
  assign if0.cmd_fn7 = c_fn7;    assign if4.cmd_fn7 = c_fn7;
  assign if0.cmd_rd = c_rd;      assign if4.cmd_rd = c_rd;
  assign if0.cmd_rs1 = c_rs1;    assign if4.cmd_rs1 = c_rs1;
  assign if0.cmd_rs2 = c_rs2;    assign if4.cmd_rs2 = c_rs2;
  assign if0.cmd_imm = c_imm;    assign if4.cmd_imm = c_imm;
  assign if0.cmd_last = c_last;  assign if4.cmd_last = c_last;

  inst_encoder #(.ADDR_W(12)) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(st0), .base_addr_i(ba0), .bus(if0.slave),
    .busy_o(busy0), .done_o(done0), .ovf_o(ovf0), .err_cnt_o(err0)
  );

  inst_encoder #(.ADDR_W(12), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start_i(st4), .base_addr_i(ba4), .bus(if4.slave),
    .busy_o(busy4), .done_o(done4), .ovf_o(ovf4), .err_cnt_o(err4)
  );

  // write / accept monitors, sampled on the falling edge
  logic [31:0] wa0[$], wd0[$], wa4[$];
  int unsigned wc0[$], ac0[$];
  int          ac4 = 0;
  always @(negedge clk) begin
    if (if0.imem_we) begin
      wa0.push_back(32'(if0.imem_addr));
      wd0.push_back(if0.imem_wdata);
      wc0.push_back(cyc);
    end
    if (if0.cmd_valid && if0.cmd_ready) ac0.push_back(cyc);
    if (if4.imem_we) wa4.push_back(32'(if4.imem_addr));
    if (if4.cmd_valid && if4.cmd_ready) ac4 = ac4 + 1;
  end

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  fn3;
    logic [6:0]  fn7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] fn3,
                              input logic [6:0] fn7, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [31:0] exp, input logic ill);
    vec_t v;
    v.fmt = fmt; v.op = op; v.fn3 = fn3; v.fn7 = fn7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp = exp; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // called at posedge+1; leaves at posedge+1 after the start edge
  task automatic do_start(input int sel, input logic [11:0] base);
    if (sel == 0) begin st0 = 1'b1; ba0 = base; end
    else          begin st4 = 1'b1; ba4 = base; end
    @(posedge clk); #1;
    st0 = 1'b0; st4 = 1'b0;
  endtask

  // offers one command; returns at posedge+1 after the accepting edge (ok=1) or on timeout
  task automatic push(input int sel, input vec_t v, input logic last, input int budget, output bit ok);
    logic rdy;
    c_fmt = v.fmt; c_op = v.op; c_fn3 = v.fn3; c_fn7 = v.fn7;
    c_rd = v.rd; c_rs1 = v.rs1; c_rs2 = v.rs2; c_imm = v.imm; c_last = last;
    if (sel == 0) c_v0 = 1'b1; else c_v4 = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      rdy = (sel == 0) ? if0.cmd_ready : if4.cmd_ready;
      if (rdy) ok = 1'b1;
      @(posedge clk); #1;
    end
    c_v0 = 1'b0; c_v4 = 1'b0; c_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int nacc, nw, exp_err, base_w;

    //            fmt  op     fn3 fn7    rd rs1 rs2 imm                exp            ill
    tbl[0]  = mk(1, 7'h13, 0, 7'h00, 1, 0, 0, 32'd5,            32'h00500093, 0);
    tbl[1]  = mk(4, 7'h37, 0, 7'h00, 2, 0, 0, 32'h12345000,     32'h12345137, 0);
    tbl[2]  = mk(2, 7'h23, 2, 7'h00, 0, 1, 2, 32'd8,            32'h0020A423, 0);
    tbl[3]  = mk(3, 7'h63, 0, 7'h00, 0, 0, 0, -32'sd4,          32'hFE000EE3, 0);
    tbl[4]  = mk(5, 7'h6F, 0, 7'h00, 1, 0, 0, 32'h800,          32'h001000EF, 0);
    tbl[5]  = mk(0, 7'h33, 0, 7'h20, 3, 4, 5, 32'd0,            32'h405201B3, 0);
    tbl[6]  = mk(1, 7'h13, 0, 7'h00, 1, 0, 0, -32'sd2048,       32'h80000093, 0);
    tbl[7]  = mk(1, 7'h13, 0, 7'h00, 1, 0, 0, 32'd2047,         32'h7FF00093, 0);
    tbl[8]  = mk(1, 7'h13, 0, 7'h00, 1, 0, 0, 32'd4096,         32'h00000013, 1);
    tbl[9]  = mk(1, 7'h13, 5, 7'h20, 1, 2, 0, 32'd31,           32'h41F15093, 0);
    tbl[10] = mk(1, 7'h13, 1, 7'h00, 1, 0, 0, 32'd40,           32'h00000013, 1);
    tbl[11] = mk(7, 7'h13, 0, 7'h00, 1, 0, 0, 32'd0,            32'h00000013, 1);
    tbl[12] = mk(3, 7'h63, 1, 7'h00, 0, 1, 2, 32'd4094,         32'h7E209FE3, 0);
    tbl[13] = mk(3, 7'h63, 0, 7'h00, 0, 0, 0, 32'd3,            32'h00000013, 1);
    tbl[14] = mk(5, 7'h6F, 0, 7'h00, 0, 0, 0, -32'sd1048576,    32'h8000006F, 0);
    tbl[15] = mk(4, 7'h37, 0, 7'h00, 1, 0, 0, 32'h800,          32'h00000013, 1);
    tbl[16] = mk(2, 7'h23, 2, 7'h00, 0, 0, 0, -32'sd2049,       32'h00000013, 1);
    tbl[17] = mk(2, 7'h23, 2, 7'h00, 0, 0, 0, -32'sd1,          32'hFE002FA3, 0);

    // ---- reset state
    idle(3);
    chk("rst_flags", {31'b0, if0.cmd_ready} | {31'b0, if0.imem_we} | {29'b0, busy0, done0, ovf0}, 32'h0);
    chk("rst_addr_data", 32'(if0.imem_addr) | if0.imem_wdata, 32'h0);
    chk("rst_err", 32'(err0), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- valid held in IDLE: nothing accepted
    c_v0 = 1'b1; c_v4 = 1'b1;
    idle(6);
    chk("idle_ready", 32'(if0.cmd_ready), 32'h0);
    chk("idle_accepts", 32'(ac0.size() + ac4), 32'h0);
    chk("idle_writes", 32'(wa0.size() + wa4.size()), 32'h0);
    c_v0 = 1'b0; c_v4 = 1'b0;

    // ---- single I with last; start pulsed during its write cycle is ignored
    do_start(0, 12'h010);
    chk("t1_busy", 32'(busy0), 32'h1);
    push(0, tbl[0], 1'b1, 20, ok);
    chk("t1_accept", 32'(ok), 32'h1);
    @(posedge clk); #1;                  // write cycle (accept + 2)
    chk("t1_we", 32'(if0.imem_we), 32'h1);
    st0 = 1'b1; ba0 = 12'h300;
    @(posedge clk); #1;
    st0 = 1'b0;
    chk("t1_done", {30'b0, done0, busy0}, 32'h2);
    if (wa0.size() >= 1 && ac0.size() >= 1) begin
      chk("t1_latency", wc0[0] - ac0[0], 32'd2);
      chk("t1_addr", wa0[0], 32'h010);
      chk("t1_data", wd0[0], 32'h00500093);
    end else chk("t1_write_seen", 32'(wa0.size()), 32'd1);
    chk("t1_err", 32'(err0), 32'h0);

    // ---- valid held after last: no accept until next start
    c_v0 = 1'b1;
    idle(5);
    chk("after_last_ready", 32'(if0.cmd_ready), 32'h0);
    chk("after_last_accepts", 32'(ac0.size()), 32'd1);
    chk("after_last_writes", 32'(wa0.size()), 32'd1);
    c_v0 = 1'b0;

    // ---- table: all vectors streamed back-to-back as one load at 0x100
    do_start(0, 12'h100);
    exp_err = 0;
    for (int i = 0; i < NV; i++) begin
      push(0, tbl[i], (i == NV - 1), 20, ok);
      chk($sformatf("tbl%0d_accept", i), 32'(ok), 32'h1);
      if (tbl[i].ill) exp_err++;
    end
    for (int k = 0; k < 20 && !done0; k++) begin @(posedge clk); #1; end
    chk("tbl_done", 32'(done0), 32'h1);
    chk("tbl_err_cnt", 32'(err0), 32'(exp_err));
    chk("tbl_nwrites", 32'(wa0.size()), 32'(NV + 1));
    base_w = 1;
    for (int i = 0; i < NV; i++) begin
      if (wa0.size() > base_w + i && ac0.size() > base_w + i) begin
        chk($sformatf("tbl%0d_addr", i), wa0[base_w + i], 32'h100 + 32'(i));
        chk($sformatf("tbl%0d_data", i), wd0[base_w + i], tbl[i].exp);
        chk($sformatf("tbl%0d_latency", i), wc0[base_w + i] - ac0[base_w + i], 32'd2);
        if (i > 0) chk($sformatf("tbl%0d_rate", i), wc0[base_w + i] - wc0[base_w + i - 1], 32'd1);
      end
    end

    // ---- DEPTH=4: six commands without last, one illegal among them
    do_start(4, 12'h020);
    nacc = 0;
    push(4, tbl[0], 1'b0, 10, ok);  nacc += int'(ok);
    push(4, tbl[11], 1'b0, 10, ok); nacc += int'(ok);
    push(4, tbl[1], 1'b0, 10, ok);  nacc += int'(ok);
    push(4, tbl[2], 1'b0, 10, ok);  nacc += int'(ok);
    push(4, tbl[3], 1'b0, 10, ok);  nacc += int'(ok);
    push(4, tbl[4], 1'b0, 10, ok);  nacc += int'(ok);
    chk("ovf_accepts", 32'(nacc), 32'd4);
    chk("ovf_writes", 32'(wa4.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (wa4.size() > i) chk($sformatf("ovf_addr%0d", i), wa4[i], 32'h020 + 32'(i));
    chk("ovf_flags", {28'b0, ovf4, done4, busy4, if4.cmd_ready}, 32'h8);
    chk("ovf_err", 32'(err4), 32'd1);
    do_start(4, 12'hFFE);
    chk("restart_flags", {29'b0, ovf4, done4, busy4}, 32'h1);
    chk("restart_err", 32'(err4), 32'h0);

    // ---- address wrap: base 0xFFE accepts only two words
    nacc = 0;
    push(4, tbl[0], 1'b0, 10, ok); nacc += int'(ok);
    push(4, tbl[5], 1'b0, 10, ok); nacc += int'(ok);
    push(4, tbl[7], 1'b0, 10, ok); nacc += int'(ok);
    chk("wrap_accepts", 32'(nacc), 32'd2);
    chk("wrap_ovf", 32'(ovf4), 32'h1);
    chk("wrap_writes", 32'(wa4.size()), 32'd6);
    if (wa4.size() >= 6) begin
      chk("wrap_addr0", wa4[4], 32'hFFE);
      chk("wrap_addr1", wa4[5], 32'hFFF);
    end

    // ---- reset with two commands in flight
    do_start(0, 12'h200);
    push(0, tbl[1], 1'b0, 20, ok);
    push(0, tbl[2], 1'b0, 20, ok);
    chk("rstp_we_before", 32'(if0.imem_we), 32'h1);
    nw = wa0.size();
    #1 rst_n = 1'b0;
    #1;
    chk("rstp_flags", {27'b0, if0.imem_we, if0.cmd_ready, busy0, done0, ovf0}, 32'h0);
    chk("rstp_bus", 32'(if0.imem_addr) | if0.imem_wdata | 32'(err0), 32'h0);
    idle(2);
    @(negedge clk); rst_n = 1'b1;
    idle(6);
    chk("rstp_no_writes", 32'(wa0.size()), 32'(nw));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
